// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronises and debounces push buttons and DIP switches,
// and derives button press/release/hold pulses and a DIP change strobe.
module board_input_conditioner #(
  parameter int N_BTN       = 5,
  parameter int N_SW        = 8,
  parameter int DEB_CYCLES  = 1250000,
  parameter int HOLD_CYCLES = 125000000,
  parameter int CNT_W       = 27
) (
  input  logic             CLK_125,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] push_btn,
  input  logic [N_SW-1:0]  DIP_sw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_changed
);

  localparam int N_IN = N_BTN + N_SW;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } btn_state_t;

  logic [N_IN-1:0]  raw_s;
  logic [N_IN-1:0]  sync1_r;
  logic [N_IN-1:0]  sync2_r;
  logic [N_IN-1:0]  deb_r;
  logic [CNT_W-1:0] deb_cnt_r [N_IN];
  logic [N_BTN-1:0] btn_deb_s;
  logic [N_SW-1:0]  sw_deb_s;
  btn_state_t       state_r [N_BTN];
  logic [CNT_W-1:0] hc_r [N_BTN];

  // Buttons occupy the low bits so both input kinds share one debounce bank.
  assign raw_s     = {DIP_sw, push_btn};
  assign btn_deb_s = deb_r[N_BTN-1:0];
  assign sw_deb_s  = deb_r[N_IN-1:N_BTN];

  // Two-flop synchroniser followed by a per-bit stability counter.
  always_ff @(posedge CLK_125 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  // Per-button event FSM; level and pulses are registered together so they align.
  always_ff @(posedge CLK_125 or negedge reset_n) begin
    if (!reset_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_hold    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_RELEASED;
        hc_r[i]    <= '0;
      end
    end else begin
      btn_level   <= btn_deb_s;
      btn_press   <= '0;
      btn_release <= '0;
      btn_hold    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state_r[i])
          ST_RELEASED: begin
            if (btn_deb_s[i]) begin
              state_r[i]   <= ST_PRESSED;
              hc_r[i]      <= '0;
              btn_press[i] <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!btn_deb_s[i]) begin
              state_r[i]     <= ST_RELEASED;
              btn_release[i] <= 1'b1;
            end else if (hc_r[i] == HOLD_LAST) begin
              state_r[i]  <= ST_HELD;
              btn_hold[i] <= 1'b1;
            end else begin
              hc_r[i] <= hc_r[i] + 1'b1;
            end
          end
          ST_HELD: begin
            if (!btn_deb_s[i]) begin
              state_r[i]     <= ST_RELEASED;
              btn_release[i] <= 1'b1;
            end
          end
          default: begin
            state_r[i] <= ST_RELEASED;
            hc_r[i]    <= '0;
          end
        endcase
      end
    end
  end

  // DIP level register and a single strobe for any bit change.
  always_ff @(posedge CLK_125 or negedge reset_n) begin
    if (!reset_n) begin
      sw_level   <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_level   <= sw_deb_s;
      sw_changed <= |(sw_deb_s ^ sw_level);
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench for board_input_conditioner with short debounce/hold times.
module tb_board_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] push_btn = 5'd0;
  logic [7:0] DIP_sw = 8'd0;
  logic [4:0] btn_level, btn_press, btn_release, btn_hold;
  logic [7:0] sw_level;
  logic       sw_changed;

  typedef struct packed {
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] hold;
    logic [4:0] blevel;
    logic       chg;
    logic [7:0] slevel;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  exp_t sb_q[$];
  obs_t obs_s;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   t;

  board_input_conditioner #(
    .N_BTN(5), .N_SW(8), .DEB_CYCLES(4), .HOLD_CYCLES(20), .CNT_W(8)
  ) dut (
    .CLK_125(clk), .reset_n(reset_n), .push_btn(push_btn), .DIP_sw(DIP_sw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_hold(btn_hold), .sw_level(sw_level), .sw_changed(sw_changed)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs_s = {btn_press, btn_release, btn_hold, btn_level, sw_changed, sw_level};

  task automatic exp_ev(input int c, input logic [4:0] p, input logic [4:0] r,
                        input logic [4:0] h, input logic [4:0] bl,
                        input logic ch, input logic [7:0] sl);
    exp_t e;
    e.cyc = c;
    e.v   = {p, r, h, bl, ch, sl};
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse output is an event that must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        n_total++;
        n_bad++;
        $display("FAIL missed_event: expected at cycle %0d value %h, no matching event by cycle %0d",
                 sb_q[0].cyc, sb_q[0].v, cyc);
        void'(sb_q.pop_front());
      end
      if ((|btn_press) || (|btn_release) || (|btn_hold) || sw_changed) begin
        n_total++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: cycle %0d got %h, nothing expected", cyc, obs_s);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.v !== obs_s) begin
            n_bad++;
            $display("FAIL event: got %h at cycle %0d, want %h at cycle %0d",
                     obs_s, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    n_total++;
    if (obs_s !== '0) begin
      n_bad++;
      $display("FAIL %s: got %h want 0", name, obs_s);
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    wait_cyc(3);
    #1 check_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_cyc(3);

    // 1: single press then release, no hold
    t = cyc; push_btn[0] = 1'b1;
    exp_ev(t + 7, 5'h01, 5'h00, 5'h00, 5'h01, 1'b0, 8'h00);
    wait_cyc(10);
    t = cyc; push_btn[0] = 1'b0;
    exp_ev(t + 7, 5'h00, 5'h01, 5'h00, 5'h00, 1'b0, 8'h00);
    wait_cyc(12);

    // 2: 3-cycle glitch rejected, then bounce accepted after final stable run
    push_btn[2] = 1'b1;
    wait_cyc(3);
    push_btn[2] = 1'b0;
    wait_cyc(12);
    push_btn[2] = 1'b1;
    wait_cyc(1);
    push_btn[2] = 1'b0;
    wait_cyc(1);
    t = cyc; push_btn[2] = 1'b1;
    exp_ev(t + 7, 5'h04, 5'h00, 5'h00, 5'h04, 1'b0, 8'h00);
    wait_cyc(10);
    t = cyc; push_btn[2] = 1'b0;
    exp_ev(t + 7, 5'h00, 5'h04, 5'h00, 5'h00, 1'b0, 8'h00);
    wait_cyc(12);

    // 3: long press gives one hold pulse 20 cycles after press; short press none
    t = cyc; push_btn[4] = 1'b1;
    exp_ev(t + 7,  5'h10, 5'h00, 5'h00, 5'h10, 1'b0, 8'h00);
    exp_ev(t + 27, 5'h00, 5'h00, 5'h10, 5'h10, 1'b0, 8'h00);
    wait_cyc(30);
    t = cyc; push_btn[4] = 1'b0;
    exp_ev(t + 7, 5'h00, 5'h10, 5'h00, 5'h00, 1'b0, 8'h00);
    wait_cyc(12);
    t = cyc; push_btn[4] = 1'b1;
    exp_ev(t + 7, 5'h10, 5'h00, 5'h00, 5'h10, 1'b0, 8'h00);
    wait_cyc(10);
    t = cyc; push_btn[4] = 1'b0;
    exp_ev(t + 7, 5'h00, 5'h10, 5'h00, 5'h00, 1'b0, 8'h00);
    wait_cyc(30);

    // 4: multi-bit DIP change gives one strobe, then a single-bit change
    t = cyc; DIP_sw = 8'hA5;
    exp_ev(t + 7, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 8'hA5);
    wait_cyc(12);
    t = cyc; DIP_sw = 8'hA4;
    exp_ev(t + 7, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 8'hA4);
    wait_cyc(12);

    // 5: reset mid-press clears outputs at once; re-press after release of reset
    t = cyc; push_btn[1] = 1'b1;
    exp_ev(t + 7, 5'h02, 5'h00, 5'h00, 5'h02, 1'b0, 8'hA4);
    wait_cyc(15);
    reset_n = 1'b0;
    #1 check_zero("async_reset");
    wait_cyc(3);
    t = cyc; reset_n = 1'b1;
    exp_ev(t + 7, 5'h02, 5'h00, 5'h00, 5'h02, 1'b1, 8'hA4);
    wait_cyc(10);
    t = cyc; push_btn[1] = 1'b0;
    exp_ev(t + 7, 5'h00, 5'h02, 5'h00, 5'h00, 1'b0, 8'hA4);
    wait_cyc(12);

    // 6: everything toggles together
    t = cyc; push_btn = 5'h1F; DIP_sw = 8'h5B;
    exp_ev(t + 7, 5'h1F, 5'h00, 5'h00, 5'h1F, 1'b1, 8'h5B);
    wait_cyc(10);
    t = cyc; push_btn = 5'h00; DIP_sw = 8'hA4;
    exp_ev(t + 7, 5'h00, 5'h1F, 5'h00, 5'h00, 1'b1, 8'hA4);
    wait_cyc(15);

    n_total++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d events left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
